// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one backing memory between NUM_CH cache refill ports.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (rr_ptr then stays 0).
//
// state | meaning
// IDLE  | no transaction; arbitrate and latch the winner's request
// REQ   | strobe issued; memory busywait ignored for this one cycle
// WAIT  | strobe held until memory busywait drops, then read data captured
// DONE  | granted channel's busywait released; pointer advances
module mem_arbiter #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [NUM_CH-1:0]          CH_READ,
    input  logic [NUM_CH-1:0]          CH_WRITE,
    input  logic [NUM_CH*ADDR_W-1:0]   CH_ADDRESS,
    input  logic [NUM_CH*DATA_W-1:0]   CH_WRITEDATA,
    output logic [NUM_CH*DATA_W-1:0]   CH_READDATA,
    output logic [NUM_CH-1:0]          CH_BUSYWAIT,
    output logic                       BUSYWAIT,
    output logic                       MEM_READ,
    output logic                       MEM_WRITE,
    output logic [ADDR_W-1:0]          MEM_ADDRESS,
    output logic [DATA_W-1:0]          MEM_WRITEDATA,
    input  logic [DATA_W-1:0]          MEM_READDATA,
    input  logic                       MEM_BUSYWAIT
);

    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state;
    state_t            state_nx;
    logic [PW-1:0]     grant;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     winner;
    logic [PW-1:0]     idx;
    logic              found;
    logic              load;
    logic              finish;
    logic [NUM_CH-1:0] req;

    assign req = CH_READ | CH_WRITE;

    // First requester scanning upward from rr_ptr, wrapping at NUM_CH.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = PW'((int'(rr_ptr) + k) % NUM_CH);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    load     = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ:  state_nx = WAIT;
            WAIT: begin
                if (!MEM_BUSYWAIT) begin
                    finish   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            grant         <= '0;
            rr_ptr        <= '0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
            CH_READDATA   <= '0;
        end else begin
            if (load) begin
                // Read and write together on one channel resolves to a write.
                grant         <= winner;
                MEM_WRITE     <= CH_WRITE[winner];
                MEM_READ      <= ~CH_WRITE[winner];
                MEM_ADDRESS   <= CH_ADDRESS[int'(winner)*ADDR_W +: ADDR_W];
                MEM_WRITEDATA <= CH_WRITEDATA[int'(winner)*DATA_W +: DATA_W];
            end
            if (finish) begin
                MEM_READ  <= 1'b0;
                MEM_WRITE <= 1'b0;
                if (MEM_READ) begin
                    CH_READDATA[int'(grant)*DATA_W +: DATA_W] <= MEM_READDATA;
                end
            end
`ifndef ARB_FIXED_PRIO_EN
            if (state == DONE) begin
                rr_ptr <= (grant == PW'(NUM_CH - 1)) ? '0 : grant + PW'(1);
            end
`endif
        end
    end

    // Combinational so a cache stalls in the very cycle it raises a request.
    always_comb begin
        CH_BUSYWAIT = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            CH_BUSYWAIT[i] = RESET & req[i] & ~((state == DONE) && (grant == PW'(i)));
        end
    end

    assign BUSYWAIT = |CH_BUSYWAIT;

endmodule
